// File: rtl/spi_frame_assembler.sv
// SPI slave frame assembler: packs received bytes into BYTES_PER_FRAME-byte frames
// framed by chip select, and buffers completed frames in a first-word fall-through FIFO.
module spi_frame_assembler #(
    parameter int unsigned BYTES_PER_FRAME = 3,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_rx_dv,
    input  logic [7:0]                      i_rx_byte,
    input  logic                            i_cs_n,
    output logic                            o_frame_valid,
    output logic [8*BYTES_PER_FRAME-1:0]    o_frame_data,
    input  logic                            i_frame_ready,
    output logic                            o_frame_err,
    output logic                            o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

    localparam int unsigned FW   = 8 * BYTES_PER_FRAME;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PW + 1;
    localparam int unsigned BCW  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Chip-select synchronizer plus a third copy for edge detection
    logic cs_meta, cs_s, cs_d;
    logic cs_fall, cs_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_d    <= 1'b1;
        end else begin
            cs_meta <= i_cs_n;
            cs_s    <= cs_meta;
            cs_d    <= cs_s;
        end
    end

    assign cs_fall = cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;

    state_t          state;
    logic [BCW-1:0]  byte_cnt;
    logic [FW-1:0]   shreg;
    logic            push_req;
    logic [FW-1:0]   push_data;

    logic [FW-1:0]   shift_next;
    logic [BCW-1:0]  cnt_inc;
    logic            frame_done;
    logic            partial_left;

    always_comb begin
        shift_next   = FW'({shreg, i_rx_byte});
        cnt_inc      = byte_cnt + BCW'(1);
        frame_done   = (state == ACTIVE) && i_rx_dv && (cnt_inc == BCW'(BYTES_PER_FRAME));
        // Bytes still held after this cycle's byte (if any) has been taken
        partial_left = i_rx_dv ? !frame_done : (byte_cnt != '0);
    end

    // Framing FSM: byte assembly, frame hand-off and error detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            shreg       <= '0;
            push_req    <= 1'b0;
            push_data   <= '0;
            o_frame_err <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rx_dv) begin
                        o_frame_err <= 1'b1;
                    end
                    if (cs_fall) begin
                        state    <= ACTIVE;
                        byte_cnt <= '0;
                        shreg    <= '0;
                    end
                end
                ACTIVE: begin
                    if (i_rx_dv) begin
                        shreg <= shift_next;
                        if (frame_done) begin
                            push_req  <= 1'b1;
                            push_data <= shift_next;
                            byte_cnt  <= '0;
                        end else begin
                            byte_cnt <= cnt_inc;
                        end
                    end
                    if (cs_rise) begin
                        state <= IDLE;
                        if (partial_left) begin
                            o_frame_err <= 1'b1;
                            byte_cnt    <= '0;
                            shreg       <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO, first-word fall-through
    logic [FW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count, count_next;
    logic            full, pop, push_ok;

    always_comb begin
        full    = (count == CNTW'(FIFO_DEPTH));
        pop     = o_frame_valid & i_frame_ready;
        push_ok = push_req & (~full | pop);
        case ({push_ok, pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_frame_valid <= 1'b0;
            o_overflow    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_overflow    <= push_req & full & ~pop;
            count         <= count_next;
            o_frame_valid <= (count_next != '0);
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    assign o_frame_data = mem[rd_ptr];
    assign o_fifo_count = count;

endmodule
